// File: rtl/qcv_controller.sv
`default_nettype none
// ============================================================================
// Module   : qcv_controller
// Brief    : Trap and boot sequencer for the qcv core. Runs the boot
//            handshake (mtvec init, first PC set), prioritises synchronous
//            exceptions from ID/LSU, drives the CSR save strobes with cause
//            and trap value, and redirects IF to the trap vector or to mepc.
// Config   : QCV_MRET_EN - when defined, MRET flushes ID, pulses
//            csr_restore_mret_o and redirects IF to mepc. When undefined,
//            MRET is reported as an illegal instruction.
// Revision : 1.0 - initial release
// ============================================================================
module qcv_controller (
  input  logic        clk_i,
  input  logic        rst_ni,

  // ID stage status
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic        illegal_insn_i,
  input  logic        ecall_insn_i,
  input  logic        ebreak_insn_i,
  input  logic        mret_insn_i,

  // LSU fault reporting for the ID instruction
  input  logic        lsu_load_err_i,
  input  logic        lsu_store_err_i,
  input  logic [31:0] lsu_addr_i,

  // IF / ID control
  output logic        instr_req_o,
  output logic        pc_set_o,
  output logic [1:0]  pc_mux_o,
  output logic        halt_if_o,
  output logic        flush_id_o,

  // CSR file control
  output logic        csr_mtvec_init_o,
  output logic        csr_save_id_o,
  output logic        csr_save_cause_o,
  output logic [6:0]  csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic        csr_restore_mret_o,

  output logic        ctrl_busy_o
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_BOOT_SET    = 3'd1,
    ST_FIRST_FETCH = 3'd2,
    ST_DECODE      = 3'd3,
    ST_FLUSH       = 3'd4
  } state_e;

  // What the pending flush is for: a synchronous exception or an MRET return
  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERET = 1'b1
  } kind_e;

  localparam logic [6:0] c_CAUSE_ILLEGAL     = 7'd2;
  localparam logic [6:0] c_CAUSE_BREAKPOINT  = 7'd3;
  localparam logic [6:0] c_CAUSE_LOAD_FAULT  = 7'd5;
  localparam logic [6:0] c_CAUSE_STORE_FAULT = 7'd7;
  localparam logic [6:0] c_CAUSE_ECALL_M     = 7'd11;

  localparam logic [1:0] c_PC_BOOT  = 2'b00;
  localparam logic [1:0] c_PC_MTVEC = 2'b01;
`ifdef QCV_MRET_EN
  localparam logic [1:0] c_PC_MEPC  = 2'b10;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e      r_state;
  kind_e       r_kind;
  logic [6:0]  r_cause;
  logic [31:0] r_mtval;

  // --------------------------------------------------------------------------
  // Trap source qualification
  // --------------------------------------------------------------------------
  logic        w_illegal;
  logic        w_src_any;
  logic        w_trap_req;
  logic        w_mret_req;
  logic [6:0]  w_cause;
  logic [31:0] w_mtval;

`ifdef QCV_MRET_EN
  // MRET is a legal return; it only wins when no exception source is active
  assign w_illegal  = illegal_insn_i;
  assign w_mret_req = instr_valid_i & mret_insn_i & ~w_src_any;
`else
  // Without MRET support the opcode is simply undecodable and shares the
  // illegal-instruction priority slot
  assign w_illegal  = illegal_insn_i | mret_insn_i;
  assign w_mret_req = 1'b0;
`endif

  assign w_src_any  = lsu_load_err_i | lsu_store_err_i | w_illegal |
                      ecall_insn_i   | ebreak_insn_i;

  // Sources are only meaningful while ID actually holds an instruction
  assign w_trap_req = instr_valid_i & w_src_any;

  // Fixed-priority selection of cause and trap value among active sources
  always_comb begin
    w_cause = '0;
    w_mtval = '0;
    if (lsu_load_err_i) begin
      w_cause = c_CAUSE_LOAD_FAULT;
      w_mtval = lsu_addr_i;
    end else if (lsu_store_err_i) begin
      w_cause = c_CAUSE_STORE_FAULT;
      w_mtval = lsu_addr_i;
    end else if (w_illegal) begin
      w_cause = c_CAUSE_ILLEGAL;
      w_mtval = instr_i;
    end else if (ecall_insn_i) begin
      w_cause = c_CAUSE_ECALL_M;
      w_mtval = '0;
    end else if (ebreak_insn_i) begin
      w_cause = c_CAUSE_BREAKPOINT;
      w_mtval = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: boot sequence, then DECODE <-> FLUSH on each trap or MRET.
  // Cause and trap value are captured on entry to FLUSH so the CSR file sees
  // a stable value for the whole save cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RESET;
      r_kind  <= KIND_EXC;
      r_cause <= '0;
      r_mtval <= '0;
    end else begin
      case (r_state)
        ST_RESET:       r_state <= ST_BOOT_SET;
        ST_BOOT_SET:    r_state <= ST_FIRST_FETCH;
        ST_FIRST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_trap_req) begin
            r_cause <= w_cause;
            r_mtval <= w_mtval;
            r_kind  <= KIND_EXC;
            r_state <= ST_FLUSH;
          end else if (w_mret_req) begin
            r_kind  <= KIND_ERET;
            r_state <= ST_FLUSH;
          end
        end
        // Trap inputs are deliberately ignored here; at most one trap per
        // two cycles can therefore be taken
        ST_FLUSH:       r_state <= ST_DECODE;
        default:        r_state <= ST_RESET;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Everything is a function of the state flops except the
  // same-cycle flush/halt in DECODE, which must kill the trapping instruction
  // before it commits side effects and hold the ID PC for the save cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    instr_req_o        = 1'b0;
    pc_set_o           = 1'b0;
    pc_mux_o           = c_PC_BOOT;
    halt_if_o          = 1'b0;
    flush_id_o         = 1'b0;
    csr_mtvec_init_o   = 1'b0;
    csr_save_id_o      = 1'b0;
    csr_save_cause_o   = 1'b0;
    csr_mcause_o       = '0;
    csr_mtval_o        = '0;
    csr_restore_mret_o = 1'b0;
    ctrl_busy_o        = (r_state != ST_RESET);

    case (r_state)
      ST_BOOT_SET: begin
        csr_mtvec_init_o = 1'b1;
        pc_set_o         = 1'b1;
        pc_mux_o         = c_PC_BOOT;
        instr_req_o      = 1'b1;
      end
      ST_FIRST_FETCH: begin
        instr_req_o = 1'b1;
      end
      ST_DECODE: begin
        instr_req_o = 1'b1;
        flush_id_o  = w_trap_req | w_mret_req;
        halt_if_o   = w_trap_req | w_mret_req;
      end
      ST_FLUSH: begin
        flush_id_o = 1'b1;
        halt_if_o  = 1'b1;
        pc_set_o   = 1'b1;
        if (r_kind == KIND_EXC) begin
          csr_save_id_o    = 1'b1;
          csr_save_cause_o = 1'b1;
          csr_mcause_o     = r_cause;
          csr_mtval_o      = r_mtval;
          pc_mux_o         = c_PC_MTVEC;
        end else begin
`ifdef QCV_MRET_EN
          csr_restore_mret_o = 1'b1;
          pc_mux_o           = c_PC_MEPC;
`else
          // Unreachable: the return kind is never recorded without MRET
          pc_mux_o           = c_PC_MTVEC;
`endif
        end
      end
      default: begin
        instr_req_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_qcv_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_qcv_controller
// Brief    : Self-checking bench for qcv_controller. Expected CSR save/restore
//            beats are queued when a trap is driven and compared when the
//            controller emits its FLUSH-cycle strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qcv_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        illegal_insn_i;
  logic        ecall_insn_i;
  logic        ebreak_insn_i;
  logic        mret_insn_i;
  logic        lsu_load_err_i;
  logic        lsu_store_err_i;
  logic [31:0] lsu_addr_i;

  logic        instr_req_o;
  logic        pc_set_o;
  logic [1:0]  pc_mux_o;
  logic        halt_if_o;
  logic        flush_id_o;
  logic        csr_mtvec_init_o;
  logic        csr_save_id_o;
  logic        csr_save_cause_o;
  logic [6:0]  csr_mcause_o;
  logic [31:0] csr_mtval_o;
  logic        csr_restore_mret_o;
  logic        ctrl_busy_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0]  cause;
    logic [31:0] mtval;
    logic        eret;
  } exp_t;

  exp_t sb_q[$];

  logic [47:0] flush_vec;
  logic [49:0] all_outs;

  assign flush_vec = {flush_id_o, halt_if_o, instr_req_o, csr_save_id_o,
                      csr_save_cause_o, csr_restore_mret_o, pc_set_o, pc_mux_o,
                      csr_mcause_o, csr_mtval_o};
  assign all_outs  = {instr_req_o, pc_set_o, pc_mux_o, halt_if_o, flush_id_o,
                      csr_mtvec_init_o, csr_save_id_o, csr_save_cause_o,
                      csr_mcause_o, csr_mtval_o, csr_restore_mret_o, ctrl_busy_o};

  always #5 clk_i = ~clk_i;

  qcv_controller dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .instr_valid_i      (instr_valid_i),
    .instr_i            (instr_i),
    .illegal_insn_i     (illegal_insn_i),
    .ecall_insn_i       (ecall_insn_i),
    .ebreak_insn_i      (ebreak_insn_i),
    .mret_insn_i        (mret_insn_i),
    .lsu_load_err_i     (lsu_load_err_i),
    .lsu_store_err_i    (lsu_store_err_i),
    .lsu_addr_i         (lsu_addr_i),
    .instr_req_o        (instr_req_o),
    .pc_set_o           (pc_set_o),
    .pc_mux_o           (pc_mux_o),
    .halt_if_o          (halt_if_o),
    .flush_id_o         (flush_id_o),
    .csr_mtvec_init_o   (csr_mtvec_init_o),
    .csr_save_id_o      (csr_save_id_o),
    .csr_save_cause_o   (csr_save_cause_o),
    .csr_mcause_o       (csr_mcause_o),
    .csr_mtval_o        (csr_mtval_o),
    .csr_restore_mret_o (csr_restore_mret_o),
    .ctrl_busy_o        (ctrl_busy_o)
  );

  // Expected FLUSH-cycle output vector for one queued trap or return
  function automatic logic [47:0] exp_vec(input exp_t e);
    if (e.eret)
      return {3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 7'd0, 32'd0};
    return {3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, e.cause, e.mtval};
  endfunction

  task automatic idle_inputs();
    instr_valid_i   = 1'b0;
    instr_i         = 32'h0;
    illegal_insn_i  = 1'b0;
    ecall_insn_i    = 1'b0;
    ebreak_insn_i   = 1'b0;
    mret_insn_i     = 1'b0;
    lsu_load_err_i  = 1'b0;
    lsu_store_err_i = 1'b0;
    lsu_addr_i      = 32'h0;
  endtask

  task automatic issue(input logic v, input logic ill, input logic ec,
                       input logic eb, input logic mr, input logic ld,
                       input logic st, input logic [31:0] ins,
                       input logic [31:0] addr);
    instr_valid_i   = v;
    illegal_insn_i  = ill;
    ecall_insn_i    = ec;
    ebreak_insn_i   = eb;
    mret_insn_i     = mr;
    lsu_load_err_i  = ld;
    lsu_store_err_i = st;
    instr_i         = ins;
    lsu_addr_i      = addr;
  endtask

  // Bounded wait for a save or restore strobe, sampled on falling edges
  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (csr_save_cause_o === 1'b1 || csr_restore_mret_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'h0);
    @(negedge clk_i);
    checks++;
    if (all_outs !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    idle_inputs();
  endtask

  task automatic test_boot();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (all_outs !== 50'd0) begin
      errors++;
      $display("FAIL boot_reset_cycle: got %h want 0", all_outs);
    end
    @(negedge clk_i);
    checks++;
    if ({csr_mtvec_init_o, pc_set_o, pc_mux_o, instr_req_o, ctrl_busy_o, flush_id_o, csr_mcause_o, csr_mtval_o}
        !== {1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0}) begin
      errors++;
      $display("FAIL boot_set: got init=%b set=%b mux=%b req=%b busy=%b flush=%b cause=%0d mtval=%h want 1 1 00 1 1 0 0 0",
               csr_mtvec_init_o, pc_set_o, pc_mux_o, instr_req_o, ctrl_busy_o, flush_id_o, csr_mcause_o, csr_mtval_o);
    end
    @(negedge clk_i);
    checks++;
    if ({csr_mtvec_init_o, pc_set_o, instr_req_o, ctrl_busy_o, csr_mcause_o} !== {1'b0, 1'b0, 1'b1, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL boot_first_fetch: got init=%b set=%b req=%b busy=%b cause=%0d want 0 0 1 1 0",
               csr_mtvec_init_o, pc_set_o, instr_req_o, ctrl_busy_o, csr_mcause_o);
    end
    @(negedge clk_i);
    checks++;
    if ({csr_mtvec_init_o, pc_set_o, instr_req_o, ctrl_busy_o, flush_id_o, csr_mcause_o} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL boot_decode: got init=%b set=%b req=%b busy=%b flush=%b cause=%0d want 0 0 1 1 0 0",
               csr_mtvec_init_o, pc_set_o, instr_req_o, ctrl_busy_o, flush_id_o, csr_mcause_o);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    bit ok;
    @(posedge clk_i); #1;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    sb_q.push_back('{cause: 7'd2, mtval: 32'hFFFF_FFFF, eret: 1'b0});
    @(negedge clk_i);
    checks++;
    if ({flush_id_o, halt_if_o, csr_save_cause_o} !== 3'b110) begin
      errors++;
      $display("FAIL illegal_detect: got flush/halt/save=%b%b%b want 110", flush_id_o, halt_if_o, csr_save_cause_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL illegal_save: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if ({instr_req_o, pc_set_o, flush_id_o, csr_save_cause_o, csr_mcause_o} !== {4'b1000, 7'd0}) begin
      errors++;
      $display("FAIL illegal_refetch: got req=%b set=%b flush=%b save=%b cause=%0d want 1 0 0 0 0",
               instr_req_o, pc_set_o, flush_id_o, csr_save_cause_o, csr_mcause_o);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    bit ok;
    @(posedge clk_i); #1;
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8000_0004);
    sb_q.push_back('{cause: 7'd5, mtval: 32'h8000_0004, eret: 1'b0});
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL priority_load: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
    // Store fault outranks illegal and ebreak
    @(posedge clk_i); #1;
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h0000_0FFC);
    sb_q.push_back('{cause: 7'd7, mtval: 32'h0000_0FFC, eret: 1'b0});
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL priority_store: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
    // Lone EBREAK
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_0073, 32'hFFFF_0000);
    sb_q.push_back('{cause: 7'd3, mtval: 32'h0, eret: 1'b0});
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL priority_ebreak: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
  endtask

  task automatic test_ignored();
    exp_t e;
    bit ok;
    @(posedge clk_i); #1;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0073, 32'h1);
    @(negedge clk_i);
    checks++;
    if ({flush_id_o, halt_if_o} !== 2'b00) begin
      errors++;
      $display("FAIL ignored_invalid_flush: got flush/halt=%b%b want 00", flush_id_o, halt_if_o);
    end
    // Valid instruction with no source active
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0);
    @(negedge clk_i);
    checks++;
    if ({flush_id_o, csr_save_cause_o, csr_save_id_o, pc_set_o} !== 4'b0000) begin
      errors++;
      $display("FAIL ignored_no_save: got flush/save/save_id/set=%b%b%b%b want 0000",
               flush_id_o, csr_save_cause_o, csr_save_id_o, pc_set_o);
    end
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'hDEAD_0000);
    sb_q.push_back('{cause: 7'd11, mtval: 32'h0, eret: 1'b0});
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL ignored_ecall: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
  endtask

  task automatic test_mret();
    exp_t e;
    bit ok;
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3020_0073, 32'h0);
`ifdef QCV_MRET_EN
    sb_q.push_back('{cause: 7'd0, mtval: 32'h0, eret: 1'b1});
`else
    sb_q.push_back('{cause: 7'd2, mtval: 32'h3020_0073, eret: 1'b0});
`endif
    @(negedge clk_i);
    checks++;
    if ({flush_id_o, halt_if_o} !== 2'b11) begin
      errors++;
      $display("FAIL mret_detect: got flush/halt=%b%b want 11", flush_id_o, halt_if_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL mret_flush: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
    // An exception source beats a simultaneous MRET
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3020_0073, 32'h0);
`ifdef QCV_MRET_EN
    sb_q.push_back('{cause: 7'd11, mtval: 32'h0, eret: 1'b0});
`else
    sb_q.push_back('{cause: 7'd2, mtval: 32'h3020_0073, eret: 1'b0});
`endif
    @(posedge clk_i); #1;
    idle_inputs();
    wait_strobe(1, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL mret_vs_exc: got %h want %h (strobe seen=%0d)", flush_vec, exp_vec(e), ok);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'h0);
    sb_q.push_back('{cause: 7'd11, mtval: 32'h0, eret: 1'b0});
    // During FLUSH a load fault appears; it must not disturb the saved cause
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2003, 32'hDEAD_BEE0);
    sb_q.push_back('{cause: 7'd5, mtval: 32'hDEAD_BEE0, eret: 1'b0});
    @(negedge clk_i);
    e = sb_q.pop_front();
    checks++;
    if (flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL b2b_first_save: got %h want %h", flush_vec, exp_vec(e));
    end
    // Still-active load fault is taken in the very next DECODE cycle
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if ({flush_id_o, halt_if_o, csr_save_cause_o, instr_req_o} !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_second_detect: got flush/halt/save/req=%b%b%b%b want 1101",
               flush_id_o, halt_if_o, csr_save_cause_o, instr_req_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    e = sb_q.pop_front();
    checks++;
    if (flush_vec !== exp_vec(e)) begin
      errors++;
      $display("FAIL b2b_second_save: got %h want %h", flush_vec, exp_vec(e));
    end
  endtask

  task automatic test_reset_mid_flush();
    @(posedge clk_i); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    @(posedge clk_i); #1;
    idle_inputs();
    #1;
    checks++;
    if ({csr_save_cause_o, csr_mcause_o, csr_mtval_o} !== {1'b1, 7'd7, 32'h1234_5678}) begin
      errors++;
      $display("FAIL midflush_pre: got save=%b cause=%0d mtval=%h want 1 7 12345678",
               csr_save_cause_o, csr_mcause_o, csr_mtval_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (all_outs !== 50'd0) begin
      errors++;
      $display("FAIL midflush_async_clear: got %h want 0", all_outs);
    end
    repeat (2) @(negedge clk_i);
    test_boot();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_boot();
    test_illegal();
    test_priority();
    test_ignored();
    test_mret();
    test_back_to_back();
    test_reset_mid_flush();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qcv_controller.md
# qcv_controller

Trap and boot sequencer for the qcv core. Owns the pipeline control FSM between IF, ID and the CSR file. Its jobs:
- Drives the boot handshake (mtvec init and first PC set).
- Prioritises synchronous exceptions from ID/LSU and drives the CSR save strobes, cause and trap value.
- Redirects IF to the trap vector, or to mepc on MRET.

## Interface
Parameters: none.
- clk_i  in  1  core clock
- rst_ni  in  1  reset; asynchronous, active-low
- instr_valid_i  in  1  ID holds a valid instruction this cycle
- instr_i  in  32  raw instruction word in ID; used as trap value for illegal instructions
- illegal_insn_i  in  1  ID decode is illegal; includes the CSR file's illegal-access flag
- ecall_insn_i  in  1  ID instruction is ECALL
- ebreak_insn_i  in  1  ID instruction is EBREAK
- mret_insn_i  in  1  ID instruction is MRET
- lsu_load_err_i  in  1  load access fault for the ID instruction
- lsu_store_err_i  in  1  store access fault for the ID instruction
- lsu_addr_i  in  32  faulting data address
- instr_req_o  out  1  IF may fetch
- pc_set_o  out  1  IF loads a new PC this cycle
- pc_mux_o  out  2  PC source: 00 boot_addr, 01 mtvec, 10 mepc
- halt_if_o  out  1  IF and the ID pipeline register hold
- flush_id_o  out  1  kill the ID instruction; suppresses regfile, LSU and CSR side effects
- csr_mtvec_init_o  out  1  CSR file loads mtvec from boot_addr
- csr_save_id_o  out  1  CSR file saves the ID PC to mepc
- csr_save_cause_o  out  1  CSR file saves cause, trap value and mstatus
- csr_mcause_o  out  7  exception cause code
- csr_mtval_o  out  32  exception trap value
- csr_restore_mret_o  out  1  MRET state-restore pulse
- ctrl_busy_o  out  1  core is out of reset

## Operation
FSM states are RESET, BOOT_SET, FIRST_FETCH, DECODE and FLUSH.
- **RESET**: all outputs are 0. Next state is BOOT_SET.
- **BOOT_SET**: drives csr_mtvec_init_o=1, pc_set_o=1, pc_mux_o=00 and instr_req_o=1. Next state is FIRST_FETCH.
- **FIRST_FETCH**: drives instr_req_o=1. Next state is DECODE.
- **DECODE**: drives instr_req_o=1.
  - A trap is raised only when instr_valid_i=1 and at least one source is active. Sources, in priority order:
    1. lsu_load_err_i: cause 5, mtval=lsu_addr_i
    2. lsu_store_err_i: cause 7, mtval=lsu_addr_i
    3. illegal_insn_i: cause 2, mtval=instr_i
    4. ecall_insn_i: cause 11, mtval=0
    5. ebreak_insn_i: cause 3, mtval=0
  - On a trap: flush_id_o=1 and halt_if_o=1 combinationally. cause_q and mtval_q are latched, kind_q is set to EXC, and the next state is FLUSH.
  - If no trap is active and mret_insn_i=1 with instr_valid_i=1: kind_q is set to ERET. flush_id_o=1 and halt_if_o=1, and the next state is FLUSH.
  - Exceptions take priority over MRET.
- **FLUSH**: drives flush_id_o=1, halt_if_o=1 and pc_set_o=1.
  - kind EXC: csr_save_id_o=1, csr_save_cause_o=1, csr_mcause_o=cause_q, csr_mtval_o=mtval_q, pc_mux_o=01.
  - kind ERET: csr_restore_mret_o=1, pc_mux_o=10.
  - Next state is DECODE.
  - All trap inputs are ignored in this state.
- ctrl_busy_o=1 in every state except RESET.
- csr_mcause_o and csr_mtval_o are 0 outside FLUSH/EXC.

## Timing
- Reset value of every output is 0; pc_mux_o resets to 00.
- After rst_ni deasserts:
  - first edge: RESET→BOOT_SET (boot strobes visible for 1 cycle);
  - second edge: →FIRST_FETCH;
  - third edge: →DECODE.
- Trap latency: the cause is detected in cycle N. Save strobes and the redirect are asserted for exactly 1 cycle in N+1. The first fetch from the new PC is requested in N+2.
- The ID PC stays stable from N through N+1, because halt_if_o is high in both cycles. csr_save_id_o therefore captures the trapping instruction's PC.
- Back-to-back traps: the minimum spacing is 2 cycles. No source can raise a trap while in FLUSH.
- Asserting rst_ni mid-FLUSH aborts immediately:
  - all strobes drop asynchronously;
  - cause_q and mtval_q clear to 0;
  - the FSM restarts the boot sequence.
- cause_q is 7 bits and mtval_q is 32 bits, zero-extended as listed. No arithmetic is performed.

## Configuration
- QCV_MRET_EN defined: MRET behaves as described above (ERET flush, redirect to mepc, csr_restore_mret_o pulse).
- QCV_MRET_EN undefined:
  - mret_insn_i is treated as illegal: cause 2, mtval=instr_i, same priority slot as illegal_insn_i.
  - csr_restore_mret_o is tied to 0.
  - pc_mux_o never takes the value 10.

## Test plan
- Boot: release rst_ni.
  - Expect csr_mtvec_init_o=pc_set_o=1 with pc_mux_o=00 in cycle 1 only.
  - Expect ctrl_busy_o=1 from cycle 1.
  - Expect instr_req_o=1 from cycle 1.
- Illegal instruction: instr_valid_i=1, illegal_insn_i=1, instr_i=0xFFFFFFFF.
  - Same cycle: flush_id_o=1.
  - Next cycle: csr_save_cause_o=1, csr_mcause_o=2, csr_mtval_o=0xFFFFFFFF, pc_mux_o=01.
- Priority: lsu_load_err_i=1, illegal_insn_i=1 and ecall_insn_i=1 together, lsu_addr_i=0x8000_0004.
  - Expect csr_mcause_o=5 and csr_mtval_o=0x80000004.
- Ignored sources: ecall_insn_i=1 with instr_valid_i=0 → no flush and no save. Then ecall_insn_i=1 with instr_valid_i=1 → csr_mcause_o=11, csr_mtval_o=0.
- MRET:
  - With QCV_MRET_EN: expect csr_restore_mret_o=1 and pc_mux_o=10 for 1 cycle, and no save strobes.
  - Without QCV_MRET_EN: expect csr_mcause_o=2 and csr_mtval_o=instr_i (0x30200073).
- Reset mid-FLUSH: assert rst_ni low during FLUSH.
  - Expect all outputs 0 immediately.
  - After release, expect a full boot sequence with csr_mcause_o=0.
